mac_scheduler: RTL and testbench

Time-multiplexed scheduler that shares one 16x16 multiplier (signed A × unsigned B) among several requesters: the voice envelope DACs, the filter coefficient multiply and the master volume. It replaces per-user multiplier instances and saves SB_MAC16 tiles. Requesters use a req/ack handshake, and a round-robin arbiter grants at most one operation per cycle. Each requester selects which 16-bit window of the 32-bit product it receives.

---
 rtl/mac_scheduler.sv | 127 ++++++++++++
 tb/tb_mac_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_scheduler.sv
// Round-robin shared 16x16 (signed x unsigned) multiplier with per-requester result windows.
// Define MAC_SCHEDULER_SAT_EN to saturate the result window instead of wrapping.
module mac_scheduler #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        iReq,
  input  logic [16*NUM_REQ-1:0]     iA,
  input  logic [16*NUM_REQ-1:0]     iB,
  input  logic [5*NUM_REQ-1:0]      iShift,
  output logic [NUM_REQ-1:0]        oAck,
  output logic                      oValid,
  output logic [2:0]                oId,
  output logic [NUM_REQ-1:0]        oDone,
  output logic signed [15:0]        oOut
);

  localparam int N = int'(NUM_REQ);

  logic [2:0]          r_last;
  logic                r_p_vld;
  logic signed [31:0]  r_p_prod;
  logic [4:0]          r_p_shift;
  logic [2:0]          r_p_id;
  logic                r_valid;
  logic [2:0]          r_id;
  logic [NUM_REQ-1:0]  r_done;
  logic signed [15:0]  r_out;

  logic                w_grant;
  logic [2:0]          w_gnt_id;
  logic [NUM_REQ-1:0]  w_ack;
  logic [15:0]         w_a;
  logic [15:0]         w_b;
  logic [4:0]          w_sh;
  logic [4:0]          w_sh_c;
  logic signed [31:0]  w_prod;
  logic signed [15:0]  w_win;
  logic signed [15:0]  w_res;
  logic [NUM_REQ-1:0]  w_done;
  int                  w_dist;
  int                  w_best;

  // The winner is the requester closest to last+1 in wrapping order.
  always_comb begin
    w_grant  = 1'b0;
    w_gnt_id = '0;
    w_ack    = '0;
    w_a      = '0;
    w_b      = '0;
    w_sh     = '0;
    w_best   = N;
    w_dist   = 0;
    for (int k = 0; k < N; k++) begin
      w_dist = (k + N - 1 - int'(r_last)) % N;
      if (rst_n && iReq[k] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_grant  = 1'b1;
        w_gnt_id = 3'(k);
        w_ack    = '0;
        w_ack[k] = 1'b1;
        w_a      = iA[16*k +: 16];
        w_b      = iB[16*k +: 16];
        w_sh     = iShift[5*k +: 5];
      end
    end
  end

  assign w_sh_c = (w_sh > 5'd16) ? 5'd16 : w_sh;
  assign w_prod = {{16{w_a[15]}}, w_a} * {16'h0000, w_b};

  assign w_win = 16'(r_p_prod >>> r_p_shift);

`ifdef MAC_SCHEDULER_SAT_EN
  logic signed [31:0] w_hi;
  logic               w_ovf;
  // Bits above the window must be pure sign extension, otherwise clamp.
  assign w_hi  = r_p_prod >>> (r_p_shift + 5'd15);
  assign w_ovf = (w_hi != '0) && (w_hi != '1);
  assign w_res = w_ovf ? (r_p_prod[31] ? 16'sh8000 : 16'sh7FFF) : w_win;
`else
  assign w_res = w_win;
`endif

  always_comb begin
    w_done = '0;
    for (int k = 0; k < N; k++) begin
      w_done[k] = r_p_vld && (r_p_id == 3'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= 3'(NUM_REQ - 1);
      r_p_vld   <= 1'b0;
      r_p_prod  <= '0;
      r_p_shift <= '0;
      r_p_id    <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_done    <= '0;
      r_out     <= '0;
    end else begin
      r_p_vld <= w_grant;
      if (w_grant) begin
        r_last    <= w_gnt_id;
        r_p_prod  <= w_prod;
        r_p_shift <= w_sh_c;
        r_p_id    <= w_gnt_id;
      end
      r_valid <= r_p_vld;
      r_done  <= w_done;
      if (r_p_vld) begin
        r_out <= w_res;
        r_id  <= r_p_id;
      end
    end
  end

  assign oAck   = w_ack;
  assign oValid = r_valid;
  assign oId    = r_id;
  assign oDone  = r_done;
  assign oOut   = r_out;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler with a per-cycle reference model and literal spot checks.
module tb_mac_scheduler;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      iReq = '0;
  logic [16*NREQ-1:0]   iA = '0;
  logic [16*NREQ-1:0]   iB = '0;
  logic [5*NREQ-1:0]    iShift = '0;
  logic [NREQ-1:0]      oAck;
  logic                 oValid;
  logic [2:0]           oId;
  logic [NREQ-1:0]      oDone;
  logic signed [15:0]   oOut;
  logic [15:0]          out_u;

  int checks = 0;
  int errors = 0;

  assign out_u = oOut;

  mac_scheduler #(.NUM_REQ(NREQ)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iReq   (iReq),
    .iA     (iA),
    .iB     (iB),
    .iShift (iShift),
    .oAck   (oAck),
    .oValid (oValid),
    .oId    (oId),
    .oDone  (oDone),
    .oOut   (oOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_win(input logic [15:0] a, input logic [15:0] b,
                                            input logic [4:0] sh);
    longint p;
    longint w;
    int     s;
    p = longint'($signed(a)) * longint'({48'h0, b});
    s = (sh > 5'd16) ? 16 : int'(sh);
    w = p >>> s;
`ifdef MAC_SCHEDULER_SAT_EN
    if (w > 32767) w = 32767;
    else if (w < -32768) w = -32768;
`endif
    return w[15:0];
  endfunction

  // Reference model: arbitration and a two-cycle delay line of expected results.
  int          m_last = NREQ - 1;
  logic        p1_vld = 1'b0, p2_vld = 1'b0;
  int          p1_id = 0, p2_id = 0;
  logic [15:0] p1_out = '0, p2_out = '0;
  logic [15:0] m_out = '0;
  int          m_id = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ack;
    logic [NREQ-1:0] exp_done;
    int              win;
    if (!rst_n) begin
      m_last = NREQ - 1;
      p1_vld = 1'b0;
      p2_vld = 1'b0;
      m_out  = '0;
      m_id   = 0;
      chk("rst_ack", 32'(oAck), 32'h0);
      chk("rst_valid", 32'(oValid), 32'h0);
      chk("rst_id", 32'(oId), 32'h0);
      chk("rst_done", 32'(oDone), 32'h0);
      chk("rst_out", 32'(out_u), 32'h0);
    end else begin
      win = -1;
      for (int i = 1; i <= NREQ; i++) begin
        if (win < 0 && iReq[(m_last + i) % NREQ]) win = (m_last + i) % NREQ;
      end
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk("m_ack", 32'(oAck), 32'(exp_ack));
      exp_done = '0;
      if (p2_vld) begin
        m_out = p2_out;
        m_id  = p2_id;
        exp_done[p2_id] = 1'b1;
      end
      chk("m_valid", 32'(oValid), 32'(p2_vld));
      chk("m_id", 32'(oId), 32'(m_id));
      chk("m_done", 32'(oDone), 32'(exp_done));
      chk("m_out", 32'(out_u), 32'(m_out));
      p2_vld = p1_vld;
      p2_id  = p1_id;
      p2_out = p1_out;
      p1_vld = (win >= 0);
      if (win >= 0) begin
        p1_id  = win;
        p1_out = model_win(iA[16*win +: 16], iB[16*win +: 16], iShift[5*win +: 5]);
        m_last = win;
      end
    end
  end

  task automatic set_lane(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] sh);
    iA[16*k +: 16]   = a;
    iB[16*k +: 16]   = b;
    iShift[5*k +: 5] = sh;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Lone request from requester k; result is checked two cycles after the ack.
  task automatic single(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] sh, input logic [15:0] exp);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    set_lane(k, a, b, sh);
    iReq = oh;
    #1;
    chk("lit_ack", 32'(oAck), 32'(oh));
    next_cycle();
    iReq = '0;
    next_cycle();
    chk("lit_valid", 32'(oValid), 32'h1);
    chk("lit_id", 32'(oId), 32'(k));
    chk("lit_out", 32'(out_u), 32'(exp));
  endtask

  initial begin
    logic [NREQ-1:0] one;
    logic [15:0]     sat_exp;
    one = 4'b0001;
    #1 rst_n = 1'b0;
    repeat (3) next_cycle();
    chk("lit_rst_out", 32'(out_u), 32'h0);
    rst_n = 1'b1;
    next_cycle();

    // Round robin with all four requesting for eight cycles.
    for (int k = 0; k < NREQ; k++) set_lane(k, 16'((k + 1) * 256), 16'h0003, 5'd4);
    iReq = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) iReq = '0;
      #1;
      if (c < 8) chk("rr_ack", 32'(oAck), 32'(one << (c % 4)));
      if (c >= 2) begin
        chk("rr_valid", 32'(oValid), 32'h1);
        chk("rr_id", 32'(oId), 32'((c - 2) % 4));
      end
      next_cycle();
    end
    repeat (2) next_cycle();

    single(0, 16'h7FF0, 16'h00FF, 5'd8, 16'h7F70);
    single(1, 16'h8000, 16'hFFFF, 5'd16, 16'h8000);
    single(1, 16'h8000, 16'hFFFF, 5'd31, 16'h8000);
`ifdef MAC_SCHEDULER_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8001;
`endif
    single(2, 16'h7FFF, 16'hFFFF, 5'd0, sat_exp);
    single(3, 16'h8000, 16'hFFFF, 5'd0, 16'h8000);

    // Bubbles: one result then three idle cycles holding it.
    single(2, 16'hFFFE, 16'h0010, 5'd1, 16'hFFF0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("hold_valid", 32'(oValid), 32'h0);
      chk("hold_out", 32'(out_u), 32'hFFF0);
    end

    // Reset in the cycle after the ack of requester 2.
    set_lane(2, 16'h1234, 16'h0002, 5'd0);
    iReq = 4'b0100;
    #1 chk("mid_ack", 32'(oAck), 32'h4);
    next_cycle();
    iReq  = '0;
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("mid_novalid", 32'(oValid), 32'h0);
    end
    set_lane(0, 16'h0005, 16'h0007, 5'd0);
    set_lane(3, 16'hFFFF, 16'h0003, 5'd0);
    iReq = 4'b1001;
    #1 chk("prio_ack0", 32'(oAck), 32'h1);
    next_cycle();
    iReq = 4'b1000;
    #1 chk("prio_ack3", 32'(oAck), 32'h8);
    next_cycle();
    iReq = '0;
    chk("prio_out0", 32'(out_u), 32'h0023);
    next_cycle();
    chk("prio_out3", 32'(out_u), 32'hFFFD);
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
